// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, TX/RX state encodings and the parity helper.
package uart_pkg;

   localparam logic [1:0] PAR_NONE = 2'd0;
   localparam logic [1:0] PAR_EVEN = 2'd1;
   localparam logic [1:0] PAR_ODD  = 2'd2;

   typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_e;
   typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_e;

   // Data is zero-extended to 9 bits by the caller, so extra bits never disturb the XOR.
   function automatic logic parity_calc(input logic [8:0] data, input logic [1:0] mode);
      logic p;
      p = ^data;
      if (mode == PAR_EVEN) return p;
      else if (mode == PAR_ODD) return ~p;
      else return 1'b0;
   endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Oversample tick generator: one tick every i_div+1 clocks, restartable by i_clr.
module uart_baud_gen #(
   parameter int G_DIV_WIDTH = 16
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_clr,
   input  logic [G_DIV_WIDTH-1:0] i_div,
   output logic                   o_tick
);

   logic [G_DIV_WIDTH-1:0] cnt_q;
   logic [G_DIV_WIDTH-1:0] cnt_d;

   // i_div is only looked at on a reload, so a new divisor never cuts a count short.
   always_comb begin
      cnt_d = cnt_q - G_DIV_WIDTH'(1);
      if (i_clr || (cnt_q == '0)) cnt_d = i_div;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign o_tick = (cnt_q == '0) && !i_clr;

endmodule

// File: rtl/uart_core.sv
// Full-duplex UART: independent TX and RX state machines, each paced by its own tick generator.
module uart_core
   import uart_pkg::*;
#(
   parameter int G_OVERSAMPLE  = 16,
   parameter int G_DIV_WIDTH   = 16,
   parameter int G_WORD_WIDTH  = 8,
   parameter int G_PARITY_MODE = 1,
   parameter int G_STOP_BITS   = 1
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic [G_DIV_WIDTH-1:0]  i_div,
   input  logic                    i_tx_valid,
   output logic                    o_tx_ready,
   input  logic [G_WORD_WIDTH-1:0] i_tx_data,
   output logic                    o_tx,
   output logic                    o_tx_busy,
   input  logic                    i_rx,
   output logic                    o_rx_valid,
   output logic [G_WORD_WIDTH-1:0] o_rx_data,
   output logic                    o_rx_parity_err,
   output logic                    o_rx_frame_err,
   output logic                    o_rx_break,
   output logic                    o_rx_busy
);

   localparam logic [4:0] OS_LAST   = 5'(G_OVERSAMPLE - 1);
   localparam logic [4:0] HALF_LAST = 5'(G_OVERSAMPLE / 2 - 1);
   localparam logic [3:0] BIT_LAST  = 4'(G_WORD_WIDTH - 1);
   localparam logic [3:0] STOP_LAST = 4'(G_STOP_BITS - 1);
   localparam logic [1:0] PMODE     = 2'(G_PARITY_MODE);
   localparam bit         PAR_EN    = (G_PARITY_MODE != 0);

   tx_state_e                 tx_state_q;
   logic                      tx_q, tx_ready_q, tx_busy_q, tx_par_q;
   logic [4:0]                tx_os_q;
   logic [3:0]                tx_bit_q;
   logic [G_WORD_WIDTH-1:0]   tx_shift_q;
   logic                      tx_hs, tx_tick;

   rx_state_e                 rx_state_q;
   logic                      rx_meta_q, rx_sync_q, rx_par_q;
   logic                      rx_valid_q, rx_perr_q, rx_ferr_q, rx_brk_q, rx_busy_q;
   logic [4:0]                rx_os_q;
   logic [3:0]                rx_bit_q;
   logic [G_WORD_WIDTH-1:0]   rx_shift_q, rx_data_q;
   logic                      rx_clr, rx_tick, rx_s;

   // TX handshake: a word is taken on any cycle where i_tx_valid and o_tx_ready are both high.
   assign tx_hs  = i_tx_valid && tx_ready_q;
   assign rx_s   = rx_sync_q;
   assign rx_clr = (rx_state_q == RX_IDLE) && !rx_s;

   uart_baud_gen #(.G_DIV_WIDTH(G_DIV_WIDTH)) u_tx_baud (
      .i_clk(i_clk), .i_rst(i_rst), .i_clr(tx_hs), .i_div(i_div), .o_tick(tx_tick));

   uart_baud_gen #(.G_DIV_WIDTH(G_DIV_WIDTH)) u_rx_baud (
      .i_clk(i_clk), .i_rst(i_rst), .i_clr(rx_clr), .i_div(i_div), .o_tick(rx_tick));

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         tx_state_q <= TX_IDLE;
         tx_q       <= 1'b1;
         tx_ready_q <= 1'b1;
         tx_busy_q  <= 1'b0;
         tx_par_q   <= 1'b0;
         tx_os_q    <= '0;
         tx_bit_q   <= '0;
         tx_shift_q <= '0;
      end else if (tx_state_q == TX_IDLE) begin
         if (tx_hs) begin
            tx_state_q <= TX_START;
            tx_q       <= 1'b0;
            tx_ready_q <= 1'b0;
            tx_busy_q  <= 1'b1;
            tx_shift_q <= i_tx_data;
            tx_par_q   <= parity_calc(9'(i_tx_data), PMODE);
            tx_os_q    <= '0;
            tx_bit_q   <= '0;
         end
      end else if (tx_tick) begin
         if (tx_os_q != OS_LAST) begin
            tx_os_q <= tx_os_q + 5'd1;
         end else begin
            tx_os_q <= '0;
            case (tx_state_q)
               TX_START: begin
                  tx_state_q <= TX_DATA;
                  tx_q       <= tx_shift_q[0];
                  tx_shift_q <= tx_shift_q >> 1;
               end
               TX_DATA: begin
                  if (tx_bit_q == BIT_LAST) begin
                     tx_bit_q <= '0;
                     if (PAR_EN) begin
                        tx_state_q <= TX_PARITY;
                        tx_q       <= tx_par_q;
                     end else begin
                        tx_state_q <= TX_STOP;
                        tx_q       <= 1'b1;
                     end
                  end else begin
                     tx_bit_q   <= tx_bit_q + 4'd1;
                     tx_q       <= tx_shift_q[0];
                     tx_shift_q <= tx_shift_q >> 1;
                  end
               end
               TX_PARITY: begin
                  tx_state_q <= TX_STOP;
                  tx_q       <= 1'b1;
               end
               TX_STOP: begin
                  if (tx_bit_q == STOP_LAST) begin
                     tx_state_q <= TX_IDLE;
                     tx_ready_q <= 1'b1;
                     tx_busy_q  <= 1'b0;
                  end else begin
                     tx_bit_q <= tx_bit_q + 4'd1;
                  end
               end
               default: tx_state_q <= TX_IDLE;
            endcase
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         rx_meta_q  <= 1'b1;
         rx_sync_q  <= 1'b1;
         rx_state_q <= RX_IDLE;
         rx_par_q   <= 1'b0;
         rx_valid_q <= 1'b0;
         rx_perr_q  <= 1'b0;
         rx_ferr_q  <= 1'b0;
         rx_brk_q   <= 1'b0;
         rx_busy_q  <= 1'b0;
         rx_os_q    <= '0;
         rx_bit_q   <= '0;
         rx_shift_q <= '0;
         rx_data_q  <= '0;
      end else begin
         rx_meta_q  <= i_rx;
         rx_sync_q  <= rx_meta_q;
         rx_valid_q <= 1'b0;
         if (rx_state_q == RX_IDLE) begin
            if (!rx_s) begin
               rx_state_q <= RX_START;
               rx_os_q    <= '0;
               rx_par_q   <= 1'b0;
            end
         end else if (rx_tick) begin
            if (rx_state_q == RX_START) begin
               // Half a bit in: still low means a real start bit, otherwise a glitch.
               if (rx_os_q == HALF_LAST) begin
                  rx_os_q  <= '0;
                  rx_bit_q <= '0;
                  if (!rx_s) begin
                     rx_state_q <= RX_DATA;
                     rx_busy_q  <= 1'b1;
                  end else begin
                     rx_state_q <= RX_IDLE;
                  end
               end else begin
                  rx_os_q <= rx_os_q + 5'd1;
               end
            end else if (rx_os_q != OS_LAST) begin
               rx_os_q <= rx_os_q + 5'd1;
            end else begin
               rx_os_q <= '0;
               case (rx_state_q)
                  RX_DATA: begin
                     rx_shift_q <= {rx_s, rx_shift_q[G_WORD_WIDTH-1:1]};
                     if (rx_bit_q == BIT_LAST) rx_state_q <= PAR_EN ? RX_PARITY : RX_STOP;
                     else                      rx_bit_q   <= rx_bit_q + 4'd1;
                  end
                  RX_PARITY: begin
                     rx_par_q   <= rx_s;
                     rx_state_q <= RX_STOP;
                  end
                  RX_STOP: begin
                     rx_valid_q <= 1'b1;
                     rx_data_q  <= rx_shift_q;
                     rx_perr_q  <= PAR_EN && (rx_par_q != parity_calc(9'(rx_shift_q), PMODE));
                     rx_ferr_q  <= !rx_s;
                     rx_brk_q   <= !rx_s && (rx_shift_q == '0) && !rx_par_q;
                     rx_busy_q  <= 1'b0;
                     rx_state_q <= RX_IDLE;
                  end
                  default: rx_state_q <= RX_IDLE;
               endcase
            end
         end
      end
   end

   assign o_tx            = tx_q;
   assign o_tx_ready      = tx_ready_q;
   assign o_tx_busy       = tx_busy_q;
   assign o_rx_valid      = rx_valid_q;
   assign o_rx_data       = rx_data_q;
   assign o_rx_parity_err = rx_perr_q;
   assign o_rx_frame_err  = rx_ferr_q;
   assign o_rx_break      = rx_brk_q;
   assign o_rx_busy       = rx_busy_q;

endmodule
